// File: rtl/clock_mode_ctrl.sv
// Mode controller for the clock/calendar: NORMAL plus one EDIT state per field, with blink, increment strobes and
// an optional inactivity timeout back to NORMAL (enabled by defining MODE_TIMEOUT_EN).
module clock_mode_ctrl #(
  parameter int N_FIELD   = 6,
  parameter int BLINK_DIV = 25_000_000,
  parameter int TIMEOUT_S = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           btn_mode,
  input  logic                           btn_inc,
  input  logic                           tick_1s,
  output logic [$clog2(N_FIELD+1)-1:0]   state,
  output logic [N_FIELD-1:0]             enable_display,
  output logic [N_FIELD-1:0]             enable_cnt,
  output logic                           enable_pulse_1s,
  output logic                           inc_pulse
);

  localparam int SW = $clog2(N_FIELD + 1);
  localparam int BW = $clog2(BLINK_DIV);

  localparam logic [SW-1:0] S_NORMAL  = '0;
  localparam logic [SW-1:0] S_LAST    = SW'(N_FIELD);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  if (N_FIELD < 1 || BLINK_DIV < 2 || TIMEOUT_S < 1) begin : g_param_check
    $error("clock_mode_ctrl: illegal parameter value");
  end

  logic [SW-1:0]      state_nxt;
  logic [BW-1:0]      blink_cnt;
  logic [BW-1:0]      blink_cnt_nxt;
  logic               blink_phase;
  logic               blink_phase_nxt;
  logic [N_FIELD-1:0] disp_nxt;
  logic [N_FIELD-1:0] cnt_en_nxt;
  logic               pulse_nxt;
  logic               inc_nxt;
  logic               in_edit;
  logic               inc_accept;
  logic               timeout_hit;

  assign in_edit    = (state != S_NORMAL);
  // Mode wins over a simultaneous increment.
  assign inc_accept = in_edit & btn_inc & ~btn_mode;

`ifdef MODE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_S + 1);

  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_cnt_nxt;

  // Any button in the expiring-tick cycle clears the counter first, so the timeout is dropped.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    timeout_hit  = 1'b0;
    if (btn_mode || btn_inc || !in_edit) begin
      idle_cnt_nxt = '0;
    end else if (tick_1s) begin
      if (idle_cnt == IW'(TIMEOUT_S - 1)) begin
        timeout_hit  = 1'b1;
        idle_cnt_nxt = '0;
      end else begin
        idle_cnt_nxt = idle_cnt + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
    end
  end
`else
  logic unused_tick;

  assign unused_tick = tick_1s;
  assign timeout_hit = 1'b0;
`endif

  // State register, together with the blink generator and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_NORMAL;
      blink_cnt       <= '0;
      blink_phase     <= 1'b1;
      enable_display  <= '1;
      enable_cnt      <= '1;
      enable_pulse_1s <= 1'b1;
      inc_pulse       <= 1'b0;
    end else begin
      state           <= state_nxt;
      blink_cnt       <= blink_cnt_nxt;
      blink_phase     <= blink_phase_nxt;
      enable_display  <= disp_nxt;
      enable_cnt      <= cnt_en_nxt;
      enable_pulse_1s <= pulse_nxt;
      inc_pulse       <= inc_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (btn_mode) begin
      state_nxt = (state == S_LAST) ? S_NORMAL : state + SW'(1);
    end else if (timeout_hit) begin
      state_nxt = S_NORMAL;
    end
  end

  // Blink restarts at phase 1 on every EDIT entry and every accepted increment; it idles in NORMAL.
  always_comb begin
    blink_cnt_nxt   = '0;
    blink_phase_nxt = 1'b1;
    if (state_nxt != S_NORMAL && !btn_mode && !inc_accept) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        blink_cnt_nxt   = blink_cnt + BW'(1);
        blink_phase_nxt = blink_phase;
      end
    end
  end

  // Output logic, evaluated on next-state values so the registered outputs track the state with no extra lag.
  always_comb begin
    pulse_nxt  = (state_nxt == S_NORMAL);
    inc_nxt    = inc_accept;
    disp_nxt   = '1;
    cnt_en_nxt = '1;
    for (int k = 0; k < N_FIELD; k++) begin
      if (state_nxt != S_NORMAL) begin
        cnt_en_nxt[k] = (state_nxt == SW'(k + 1));
        if (state_nxt == SW'(k + 1)) begin
          disp_nxt[k] = blink_phase_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed self-checking bench for clock_mode_ctrl with N_FIELD=6, BLINK_DIV=4, TIMEOUT_S=3.
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       tick_1s;
  logic [2:0] state;
  logic [5:0] enable_display;
  logic [5:0] enable_cnt;
  logic       enable_pulse_1s;
  logic       inc_pulse;

  int passed = 0;
  int total  = 0;

  clock_mode_ctrl #(.N_FIELD(6), .BLINK_DIV(4), .TIMEOUT_S(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_mode        (btn_mode),
    .btn_inc         (btn_inc),
    .tick_1s         (tick_1s),
    .state           (state),
    .enable_display  (enable_display),
    .enable_cnt      (enable_cnt),
    .enable_pulse_1s (enable_pulse_1s),
    .inc_pulse       (inc_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge, are sampled on the next rising edge, and are dropped on the falling edge after.
  task automatic press(input logic m, input logic i, input logic t);
    btn_mode = m;
    btn_inc  = i;
    tick_1s  = t;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1s  = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [5:0] exp_cnt;
    logic [5:0] exp_disp;

    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; tick_1s = 1'b0;
    cyc(2);
    rst = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_disp", 32'(enable_display), 32'h3f);
    check("rst_cnt", 32'(enable_cnt), 32'h3f);
    check("rst_pulse", 32'(enable_pulse_1s), 32'd1);
    check("rst_inc", 32'(inc_pulse), 32'd0);

    // Mode walk through every EDIT state and back to NORMAL.
    for (int i = 0; i < 7; i++) begin
      press(1'b1, 1'b0, 1'b0);
      exp_cnt = (i < 6) ? (6'b000001 << i) : 6'b111111;
      check("walk_state", 32'(state), 32'((i + 1) % 7));
      check("walk_cnt", 32'(enable_cnt), 32'(exp_cnt));
      check("walk_pulse", 32'(enable_pulse_1s), (i < 6) ? 32'd0 : 32'd1);
      cyc(9);
    end

    // Blink in EDIT_2: phase flips every 4 cycles after entry.
    repeat (3) press(1'b1, 1'b0, 1'b0);
    check("blink_entry_state", 32'(state), 32'd3);
    check("blink_entry_disp", 32'(enable_display), 32'h3f);
    for (int c = 1; c <= 16; c++) begin
      cyc(1);
      exp_disp = (((c / 4) % 2) == 0) ? 6'b111111 : 6'b111011;
      check("blink_disp", 32'(enable_display), 32'(exp_disp));
    end
    repeat (4) press(1'b1, 1'b0, 1'b0);
    check("blink_exit_state", 32'(state), 32'd0);

    // Increment in EDIT_1 restarts the blink.
    repeat (2) press(1'b1, 1'b0, 1'b0);
    cyc(5);
    check("inc_pre_disp", 32'(enable_display), 32'h3d);
    press(1'b0, 1'b1, 1'b0);
    check("inc_pulse_hi", 32'(inc_pulse), 32'd1);
    check("inc_state", 32'(state), 32'd2);
    check("inc_restart_disp", 32'(enable_display), 32'h3f);
    cyc(1);
    check("inc_pulse_lo", 32'(inc_pulse), 32'd0);
    cyc(2);
    check("inc_hold_disp", 32'(enable_display), 32'h3f);
    cyc(1);
    check("inc_toggle_disp", 32'(enable_display), 32'h3d);

    // Mode and increment together: mode wins.
    press(1'b1, 1'b1, 1'b0);
    check("both_state", 32'(state), 32'd3);
    check("both_cnt", 32'(enable_cnt), 32'h04);
    check("both_inc", 32'(inc_pulse), 32'd0);
    cyc(1);
    check("both_inc_next", 32'(inc_pulse), 32'd0);

    // Increment ignored in NORMAL.
    repeat (4) press(1'b1, 1'b0, 1'b0);
    check("norm_state", 32'(state), 32'd0);
    press(1'b0, 1'b1, 1'b0);
    check("norm_inc", 32'(inc_pulse), 32'd0);
    check("norm_inc_cnt", 32'(enable_cnt), 32'h3f);
    cyc(1);
    check("norm_inc_next", 32'(inc_pulse), 32'd0);

`ifdef MODE_TIMEOUT_EN
    // Three idle ticks return to NORMAL.
    press(1'b1, 1'b0, 1'b0);
    check("to_entry", 32'(state), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    check("to_two_ticks", 32'(state), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("to_expire", 32'(state), 32'd0);
    check("to_expire_pulse", 32'(enable_pulse_1s), 32'd1);
    check("to_expire_disp", 32'(enable_display), 32'h3f);

    // Increment between ticks 2 and 3 restarts the count.
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    check("to_inc_pulse", 32'(inc_pulse), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    check("to_delayed", 32'(state), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("to_delayed_expire", 32'(state), 32'd0);

    // Increment coinciding with the expiring tick cancels the timeout.
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b1);
    check("to_prec_state", 32'(state), 32'd1);
    check("to_prec_inc", 32'(inc_pulse), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b0, 1'b1);
    check("to_prec_hold", 32'(state), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("to_prec_expire", 32'(state), 32'd0);
`else
    // Without the timeout, ticks never leave EDIT.
    press(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      press(1'b0, 1'b0, 1'b1);
      cyc(1);
    end
    check("noto_state", 32'(state), 32'd1);
    check("noto_pulse", 32'(enable_pulse_1s), 32'd0);
    repeat (6) press(1'b1, 1'b0, 1'b0);
    check("noto_exit", 32'(state), 32'd0);
`endif

    // Reset in EDIT_4 while the blink phase is low.
    repeat (5) press(1'b1, 1'b0, 1'b0);
    cyc(5);
    check("mid_state", 32'(state), 32'd5);
    check("mid_disp", 32'(enable_display), 32'h2f);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_disp", 32'(enable_display), 32'h3f);
    check("mid_rst_cnt", 32'(enable_cnt), 32'h3f);
    check("mid_rst_pulse", 32'(enable_pulse_1s), 32'd1);
    check("mid_rst_inc", 32'(inc_pulse), 32'd0);

    // Blink counter restarts cleanly after reset.
    press(1'b1, 1'b0, 1'b0);
    cyc(3);
    check("post_rst_hold", 32'(enable_display), 32'h3f);
    cyc(1);
    check("post_rst_toggle", 32'(enable_display), 32'h3e);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
